mux_nto1_pipe: RTL and testbench
================================

MUX_NTO1_PIPE -- requirements
Module: mux_nto1_pipe

Interface
REQ-001 Parameter W, default 16: data width per channel in bits, 1..64.
REQ-002 Parameter N, default 4: number of input channels, 2..16.
REQ-003 Parameter RR, default 0: arbitration mode; 0 = fixed select from sel, 1 = round-robin across valid channels.
REQ-004 Derived SW = max(1, clog2(N)): select and channel-tag width.
REQ-005 clkpos  input  1  sole clock, rising-edge active.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 vdd, vss  input  1 each  supply pins for netlist compatibility, no logic function.
REQ-008 in_data  input  N*W  channel i occupies bits [i*W+W-1 : i*W].
REQ-009 in_valid  input  N  per-channel valid.
REQ-010 in_ready  output  N  per-channel ready; transfer on channel i when in_valid[i] and in_ready[i] are both high at a clkpos edge.
REQ-011 sel  input  SW  channel select, used only when RR=0.
REQ-012 out_data  output  W  registered selected data.
REQ-013 out_chan  output  SW  registered index of the channel that supplied out_data.
REQ-014 out_valid  output  1  output register holds valid data.
REQ-015 out_ready  input  1  downstream accepts when out_valid and out_ready are both high at an edge.

Function
REQ-016 Pipeline: single output register stage; load enable ld = !out_valid | out_ready; latency 1 cycle from input transfer to out_valid.
REQ-017 Grant, RR=0: g = sel when sel < N and in_valid[sel]; otherwise no grant; sel >= N never grants.
REQ-018 Grant, RR=1: g = first valid channel found searching upward from (ptr+1) mod N, wrapping; no grant when in_valid is all zero.
REQ-019 in_ready[i] = ld & (grant exists) & (i == g); at most one in_ready bit is high; in_ready is combinational from the current-cycle inputs and state.
REQ-020 On an edge with ld high and a grant: out_data <= channel g data, out_chan <= g, out_valid <= 1.
REQ-021 On an edge with ld high and no grant: out_valid <= 0; out_data and out_chan hold.
REQ-022 On an edge with ld low (stall: out_valid=1, out_ready=0): out_data, out_chan and out_valid hold, and no in_ready is asserted.
REQ-023 Simultaneous out_ready and a new grant in one cycle: downstream consumes the old word and the new word loads in the same edge, sustaining 1 word/cycle.
REQ-024 RR pointer ptr (SW bits) updates to g only on an edge where an input transfer occurs; it holds otherwise; pointer arithmetic wraps mod N, not mod 2^SW.
REQ-025 RR fairness: with every channel continuously valid and out_ready=1, the grant order is ptr+1, ptr+2, ..., wrapping, with each channel served once per N transfers.
REQ-026 A change of sel during a stall has no effect until ld is high again; the channel is chosen in the cycle the transfer occurs.
REQ-027 X on unselected in_data lanes shall not propagate to out_data.

Reset
REQ-028 rst high asynchronously forces out_valid=0, out_data=0, out_chan=0, ptr=N-1 (so the first RR grant searches from channel 0); the resulting in_ready=0 follows combinationally.
REQ-029 While rst is high, in_ready shall be all zero regardless of inputs.
REQ-030 Reset asserted mid-transfer discards the output word; the first edge after rst deasserts behaves as from the empty state.

Verification
REQ-031 RR=0, N=4, W=16: sel=2, in_data ch2=16'hA5A5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100; next edge out_data=16'hA5A5, out_chan=2, out_valid=1.
REQ-032 Stall: out_valid=1 holding 16'h1234, out_ready=0, in_valid=4'b1111 -> in_ready=0 and out_data stays 16'h1234 for 5 cycles; raising out_ready gives a new word on the next edge.
REQ-033 RR=1, N=4, all valid, out_ready=1 from reset -> out_chan sequence 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
REQ-034 RR=1, in_valid=4'b1001, ptr=0 -> grant 3, then 0, then 3; channels 1 and 2 are never granted.
REQ-035 RR=0, sel=3, in_valid=4'b0111 -> no grant; out_valid drops to 0 after the current word is consumed.
REQ-036 rst pulsed high between edges while out_valid=1 -> out_valid=0, out_data=0, out_chan=0 immediately, without waiting for a clkpos edge.

Source files
------------

// File: rtl/mux_nto1_pipe.sv
// mux_nto1_pipe: N-to-1 valid/ready mux with fixed or round-robin grant
// feeding a single registered output stage.
module mux_nto1_pipe #(
  parameter int W = 16,
  parameter int N = 4,
  parameter int RR = 0,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clkpos,
  input  logic            rst,
  input  logic            vdd,
  input  logic            vss,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [SW-1:0]   sel,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_chan,
  output logic            out_valid,
  input  logic            out_ready
);
  logic [SW-1:0] ptr, g, c;
  logic [W-1:0] gdata;
  logic has, ld, unused;
  assign unused = vdd ^ vss;
  assign ld = !out_valid || out_ready;
  assign in_ready = (ld && has && !rst) ? N'(1) << g : '0;
  always_comb begin
    has = 1'b0;
    g = '0;
    c = '0;
    if (RR == 0) begin
      for (int i = 0; i < N; i++)
        if (SW'(i) == sel && in_valid[i]) begin
          has = 1'b1;
          g = SW'(i);
        end
    end else begin
      // walk from farthest to nearest so the channel closest after ptr wins
      for (int k = N; k >= 1; k--) begin
        c = SW'((int'(ptr) + k >= N) ? int'(ptr) + k - N : int'(ptr) + k);
        if (in_valid[c]) begin
          has = 1'b1;
          g = c;
        end
      end
    end
  end
  always_comb begin
    gdata = '0;
    for (int i = 0; i < N; i++)
      if (SW'(i) == g) gdata = in_data[i*W +: W];
  end
  always_ff @(posedge clkpos or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
      ptr <= SW'(N - 1);
    end else if (ld) begin
      out_valid <= has;
      if (has) begin
        out_data <= gdata;
        out_chan <= g;
        ptr <= g;
      end
    end
endmodule

// File: tb/tb_mux_nto1_pipe.sv
// tb_mux_nto1_pipe: checks fixed-select and round-robin instances against a
// queue-free behavioural model plus directed vector tables and sequences.
module tb_mux_nto1_pipe;
  localparam int W = 16;
  localparam int N = 4;
  logic clkpos = 1'b0;
  logic rst = 1'b1;
  logic vdd = 1'b1;
  logic vss = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0] in_valid = '0;
  logic [1:0] sel = '0;
  logic out_ready = 1'b0;
  logic [N-1:0] rdy [2];
  logic [W-1:0] od [2];
  logic [1:0] oc [2];
  logic ov [2];
  logic mv [2];
  logic [W-1:0] md [2];
  logic [1:0] mc [2];
  logic [1:0] mp [2];
  int checks = 0;
  int errors = 0;

  mux_nto1_pipe #(.W(W), .N(N), .RR(0)) u0 (
    .clkpos(clkpos), .rst(rst), .vdd(vdd), .vss(vss), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy[0]), .sel(sel), .out_data(od[0]),
    .out_chan(oc[0]), .out_valid(ov[0]), .out_ready(out_ready));
  mux_nto1_pipe #(.W(W), .N(N), .RR(1)) u1 (
    .clkpos(clkpos), .rst(rst), .vdd(vdd), .vss(vss), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy[1]), .sel(sel), .out_data(od[1]),
    .out_chan(oc[1]), .out_valid(ov[1]), .out_ready(out_ready));

  always #5 clkpos = ~clkpos;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {granted, channel} from the arbitration rules: fixed select or first valid after ptr
  function automatic logic [2:0] grant(input int mode, input logic [1:0] p);
    if (mode == 0) return (int'(sel) < N && in_valid[sel]) ? {1'b1, sel} : 3'b000;
    for (int k = 1; k <= N; k++)
      if (in_valid[(int'(p) + k) % N]) return {1'b1, 2'((int'(p) + k) % N)};
    return 3'b000;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0;
      md[m] = '0;
      mc[m] = '0;
      mp[m] = 2'(N - 1);
    end
  endtask

  task automatic check_outs();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("out_valid[rr=%0d]", m), 64'(ov[m]), 64'(mv[m]));
      chk($sformatf("out_data[rr=%0d]", m), 64'(od[m]), 64'(md[m]));
      chk($sformatf("out_chan[rr=%0d]", m), 64'(oc[m]), 64'(mc[m]));
    end
  endtask

  task automatic step();
    logic [2:0] gr [2];
    logic ld [2];
    #1;
    for (int m = 0; m < 2; m++) begin
      gr[m] = grant(m, mp[m]);
      ld[m] = !mv[m] || out_ready;
      chk($sformatf("in_ready[rr=%0d]", m), 64'(rdy[m]),
          64'((ld[m] && gr[m][2]) ? (4'b0001 << gr[m][1:0]) : 4'b0000));
    end
    @(posedge clkpos);
    for (int m = 0; m < 2; m++)
      if (ld[m]) begin
        mv[m] = gr[m][2];
        if (gr[m][2]) begin
          md[m] = in_data[int'(gr[m][1:0])*W +: W];
          mc[m] = gr[m][1:0];
          mp[m] = gr[m][1:0];
        end
      end
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    @(negedge clkpos);
    in_valid = 4'b1111;
    out_ready = 1'b1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("in_ready_in_reset_rr0", 64'(rdy[0]), 64'(0));
    chk("in_ready_in_reset_rr1", 64'(rdy[1]), 64'(0));
    check_outs();
    @(negedge clkpos);
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] vld;
    logic ordy;
    logic [3:0] rdy;
    logic v;
    logic [15:0] d;
    logic [1:0] c;
  } vec_t;

  vec_t tbl [7];
  int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
  int exp_rr2 [3] = '{3, 0, 3};

  initial begin
    tbl[0] = '{2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 16'hA5A5, 2'd2};
    tbl[1] = '{2'd3, 4'b0111, 1'b0, 4'b0000, 1'b1, 16'hA5A5, 2'd2};
    tbl[2] = '{2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 16'hA5A5, 2'd2};
    tbl[3] = '{2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 16'h0F0F, 2'd0};
    tbl[4] = '{2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 16'h5151, 2'd1};
    tbl[5] = '{2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 16'hD3D3, 2'd3};
    tbl[6] = '{2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'hD3D3, 2'd3};
    model_reset();
    do_reset();
    in_data = {16'hD3D3, 16'hA5A5, 16'h5151, 16'h0F0F};
    for (int i = 0; i < 7; i++) begin
      sel = tbl[i].sel;
      in_valid = tbl[i].vld;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 64'(rdy[0]), 64'(tbl[i].rdy));
      step();
      chk($sformatf("tbl%0d_out_valid", i), 64'(ov[0]), 64'(tbl[i].v));
      chk($sformatf("tbl%0d_out_data", i), 64'(od[0]), 64'(tbl[i].d));
      chk($sformatf("tbl%0d_out_chan", i), 64'(oc[0]), 64'(tbl[i].c));
    end
    // stall: a held word survives five cycles of pending inputs and sel changes
    in_data = {16'hD3D3, 16'hA5A5, 16'h5151, 16'h1234};
    sel = 2'd0;
    in_valid = 4'b0001;
    out_ready = 1'b0;
    step();
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      sel = 2'(i);
      step();
      chk("stall_in_ready", 64'(rdy[0]), 64'(0));
      chk("stall_out_data", 64'(od[0]), 64'(16'h1234));
    end
    sel = 2'd2;
    out_ready = 1'b1;
    step();
    chk("stall_release_data", 64'(od[0]), 64'(16'hA5A5));
    // asynchronous reset between edges while holding a valid word
    in_valid = 4'b0000;
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_valid_rr0", 64'(ov[0]), 64'(0));
    chk("async_rst_data_rr0", 64'(od[0]), 64'(0));
    chk("async_rst_chan_rr1", 64'(oc[1]), 64'(0));
    check_outs();
    #1;
    rst = 1'b0;
    // round-robin from reset with everything valid
    do_reset();
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_all_chan", 64'(oc[1]), 64'(exp_seq[i]));
      chk("rr_all_valid", 64'(ov[1]), 64'(1));
    end
    // round-robin with only channels 0 and 3 valid, ptr at 0
    do_reset();
    in_valid = 4'b0001;
    step();
    in_valid = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_1001_chan", 64'(oc[1]), 64'(exp_rr2[i]));
    end
    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_data = {$urandom, $urandom};
      in_valid = 4'($urandom);
      sel = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
